// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared opcode/funct constants, ALU select encodings and control-bit helpers
// for the registered control/decode stage.
package ctrl_decode_pipe_pkg;

  localparam logic [5:0] OP_ALU = 6'd7;
  localparam logic [5:0] OP_LW  = 6'd8;
  localparam logic [5:0] OP_SW  = 6'd9;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_MUL = 6'd50;

  typedef enum logic [1:0] {
    SEL_ADD = 2'b00,
    SEL_SUB = 2'b01,
    SEL_AND = 2'b10,
    SEL_OR  = 2'b11
  } sel_alu_e;

  // Low (non-register) part of the control word, MSB first.
  typedef struct packed {
    logic     rf_wr;
    logic     alu1_mux;
    sel_alu_e sel_alu;
    logic     mul_st;
    logic     alu2_mux;
    logic     mem_wr;
    logic     mux_sel_wb;
  } ctrl_bits_t;

  localparam int unsigned CTRL_BITS_W = $bits(ctrl_bits_t);

  function automatic ctrl_bits_t mk_bits(input logic rf_wr, input logic alu1,
                                         input sel_alu_e sel, input logic mul,
                                         input logic alu2, input logic mem,
                                         input logic wb);
    return {rf_wr, alu1, sel, mul, alu2, mem, wb};
  endfunction

  // Control bits of the NOP word; register fields are all-ones in the full word.
  function automatic ctrl_bits_t nop_bits();
    return mk_bits(1'b0, 1'b0, SEL_AND, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Instruction-in / control-word-out handshake bundle of the decode stage.
interface ctrl_decode_pipe_if
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned CW_W = 3 * REG_AW + CTRL_BITS_W;

  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            out_valid;
  logic            out_ready;
  logic [CW_W-1:0] ctrl_out;
  logic            illegal;
  logic            mul_busy;

  modport master (
    output instr_valid, instr, out_ready,
    input  instr_ready, out_valid, ctrl_out, illegal, mul_busy
  );

  modport slave (
    input  instr_valid, instr, out_ready,
    output instr_ready, out_valid, ctrl_out, illegal, mul_busy
  );

endinterface

// File: rtl/ctrl_decode_pipe_comb.sv
// Pure combinational instruction decode: instr -> control word + illegal flag.
module ctrl_decode_pipe_comb
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  localparam int unsigned CW_W  = 3 * REG_AW + CTRL_BITS_W
) (
  input  logic [31:0]     instr,
  output logic [CW_W-1:0] cw_c,
  output logic            illegal_c
);

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [REG_AW-1:0] rs_o;
  logic [REG_AW-1:0] rt_o;
  logic [REG_AW-1:0] rd_o;
  ctrl_bits_t        bits;
  logic              unused_shamt;

  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  // Field extraction and per-opcode control bits; unknown encodings fall back to NOP.
  always_comb begin
    rs_o      = '1;
    rt_o      = '1;
    rd_o      = '1;
    bits      = nop_bits();
    illegal_c = 1'b0;
    case (op)
      OP_LW: begin
        rs_o = REG_AW'(instr[25:21]);
        rt_o = REG_AW'(instr[20:16]);
        rd_o = REG_AW'(instr[20:16]);
        bits = mk_bits(1'b1, 1'b1, SEL_ADD, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      OP_SW: begin
        rs_o = REG_AW'(instr[25:21]);
        rt_o = REG_AW'(instr[20:16]);
        rd_o = '0;
        bits = mk_bits(1'b0, 1'b1, SEL_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
      end
      OP_ALU: begin
        rs_o = REG_AW'(instr[25:21]);
        rt_o = REG_AW'(instr[20:16]);
        rd_o = REG_AW'(instr[15:11]);
        case (fn)
          FN_ADD:  bits = mk_bits(1'b1, 1'b0, SEL_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
          FN_SUB:  bits = mk_bits(1'b1, 1'b0, SEL_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
          FN_AND:  bits = mk_bits(1'b1, 1'b0, SEL_AND, 1'b0, 1'b1, 1'b0, 1'b0);
          FN_OR:   bits = mk_bits(1'b1, 1'b0, SEL_OR,  1'b0, 1'b1, 1'b0, 1'b0);
          FN_MUL:  bits = mk_bits(1'b1, 1'b0, SEL_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
          default: begin
            bits      = mk_bits(1'b1, 1'b0, SEL_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
            illegal_c = 1'b1;
          end
        endcase
      end
      default: illegal_c = 1'b1;
    endcase
    cw_c = {rs_o, rt_o, rd_o, bits};
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage: valid/ready handshake, load-use bubbling and
// multiplier issue stall around the combinational decoder.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  ctrl_decode_pipe_if.slave bus
);

  localparam int unsigned CW_W  = 3 * REG_AW + CTRL_BITS_W;
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW_W-1:0] NOP_WORD = {{(3 * REG_AW){1'b1}}, nop_bits()};

  logic [CW_W-1:0]   ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              illegal_q, illegal_d;
  logic              is_lw_q, is_lw_d;
  logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic              mul_busy_q, mul_busy_d;

  logic [CW_W-1:0]   dec_cw;
  logic              dec_illegal;
  logic [5:0]        in_op;
  logic [REG_AW-1:0] in_rs, in_rt, held_rd;
  logic              load_en, hazard, accept, in_is_mul;

  ctrl_decode_pipe_comb #(.REG_AW(REG_AW)) u_dec (
    .instr     (bus.instr),
    .cw_c      (dec_cw),
    .illegal_c (dec_illegal)
  );

  assign in_op     = bus.instr[31:26];
  assign in_rs     = REG_AW'(bus.instr[25:21]);
  assign in_rt     = REG_AW'(bus.instr[20:16]);
  assign in_is_mul = (in_op == OP_ALU) && (bus.instr[5:0] == FN_MUL);
  assign held_rd   = ctrl_q[CTRL_BITS_W +: REG_AW];

  // Handshake: load-use hazard against the held LW, stall while the multiplier is busy.
  always_comb begin
    load_en = !valid_q || bus.out_ready;
    hazard  = valid_q && is_lw_q && (held_rd != '0) &&
              ((in_rs == held_rd) ||
               (((in_op == OP_ALU) || (in_op == OP_SW)) && (in_rt == held_rd)));
    bus.instr_ready = load_en && (mul_cnt_q == '0) && !hazard;
    accept  = bus.instr_valid && bus.instr_ready;
  end

  // Next state of the output register and multiplier stall counter.
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    is_lw_d   = is_lw_q;
    mul_cnt_d = mul_cnt_q;
    if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - CNT_W'(1);
    if (load_en) begin
      if (accept) begin
        ctrl_d    = dec_cw;
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
        is_lw_d   = (in_op == OP_LW);
        if (in_is_mul) mul_cnt_d = CNT_W'(MUL_LAT - 1);
      end else begin
        ctrl_d    = NOP_WORD;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        is_lw_d   = 1'b0;
      end
    end
    mul_busy_d = (mul_cnt_d != '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= NOP_WORD;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      is_lw_q    <= 1'b0;
      mul_cnt_q  <= '0;
      mul_busy_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      is_lw_q    <= is_lw_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_busy_q <= mul_busy_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.ctrl_out  = ctrl_q;
  assign bus.illegal   = illegal_q;
  assign bus.mul_busy  = mul_busy_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios plus randomized traffic against a reference model.
module tb_ctrl_decode_pipe;

  localparam int MUL_LAT = 4;
  localparam logic [22:0] NOP_W = {15'h7fff, 8'h24};

  logic clk = 1'b0;
  logic rst_n;
  logic seen_rdy;
  int   checks = 0;
  int   errors = 0;

  ctrl_decode_pipe_if #(.REG_AW(5)) bus ();

  ctrl_decode_pipe #(.REG_AW(5), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd7, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] lw_ins(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd8, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] sw_ins(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd9, rs, rt, 16'h0008};
  endfunction

  // Reference decode: {illegal, rs, rt, rd, rf_wr, alu1, sel[1:0], mul, alu2, mem_wr, wb}.
  function automatic logic [23:0] ref_decode(input logic [31:0] i);
    logic [4:0] rs, rt, rd;
    rs = i[25:21]; rt = i[20:16]; rd = i[15:11];
    case (i[31:26])
      6'd8: return {1'b0, rs, rt, rt, 8'hC5};
      6'd9: return {1'b0, rs, rt, 5'd0, 8'h47};
      6'd7: begin
        case (i[5:0])
          6'd32:   return {1'b0, rs, rt, rd, 8'h84};
          6'd34:   return {1'b0, rs, rt, rd, 8'h94};
          6'd36:   return {1'b0, rs, rt, rd, 8'hA4};
          6'd37:   return {1'b0, rs, rt, rd, 8'hB4};
          6'd50:   return {1'b0, rs, rt, rd, 8'h88};
          default: return {1'b1, rs, rt, rd, 8'h94};
        endcase
      end
      default: return {1'b1, NOP_W};
    endcase
  endfunction

  // Drive one cycle of inputs, capture instr_ready before the edge, return #1 after it.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.out_ready   = ordy;
    #1 seen_rdy = bus.instr_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, r_ins(5'd1, 5'd2, 5'd3, 6'd32), 1'b1);
    step(1'b1, r_ins(5'd1, 5'd2, 5'd6, 6'd50), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.illegal, bus.mul_busy, bus.instr_ready, bus.ctrl_out} !==
        {1'b0, 1'b0, 1'b0, 1'b1, NOP_W}) begin
      errors++;
      $display("FAIL reset_state: got v%b i%b b%b r%b %h want v0 i0 b0 r1 %h", bus.out_valid,
               bus.illegal, bus.mul_busy, bus.instr_ready, bus.ctrl_out, NOP_W);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, r_ins(5'd1, 5'd2, 5'd3, 6'd32), 1'b1);
    checks++;
    if (seen_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_cleared: got ready %b want 1", seen_rdy);
    end
    checks++;
    if ({bus.out_valid, bus.ctrl_out} !== {1'b1, 5'd1, 5'd2, 5'd3, 8'h84}) begin
      errors++;
      $display("FAIL reset_first_issue: got v%b %h", bus.out_valid, bus.ctrl_out);
    end
  endtask

  task automatic test_add();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h1C221820, 1'b1);
    checks++;
    if (seen_rdy !== 1'b1) begin
      errors++;
      $display("FAIL add_ready: got %b want 1", seen_rdy);
    end
    checks++;
    if ({bus.out_valid, bus.illegal, bus.ctrl_out} !== {1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 8'h84}) begin
      errors++;
      $display("FAIL add_word: got v%b i%b %h want v1 i0 %h", bus.out_valid, bus.illegal,
               bus.ctrl_out, {5'd1, 5'd2, 5'd3, 8'h84});
    end
  endtask

  task automatic test_load_use();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, lw_ins(5'd1, 5'd2), 1'b1);
    checks++;
    if ({bus.out_valid, bus.illegal, bus.ctrl_out} !== {1'b1, 1'b0, 5'd1, 5'd2, 5'd2, 8'hC5}) begin
      errors++;
      $display("FAIL lw_word: got v%b i%b %h", bus.out_valid, bus.illegal, bus.ctrl_out);
    end
    step(1'b1, r_ins(5'd2, 5'd5, 5'd4, 6'd32), 1'b1);
    checks++;
    if (seen_rdy !== 1'b0) begin
      errors++;
      $display("FAIL hazard_ready: got %b want 0", seen_rdy);
    end
    checks++;
    if ({bus.out_valid, bus.ctrl_out} !== {1'b0, NOP_W}) begin
      errors++;
      $display("FAIL hazard_bubble: got v%b %h want v0 %h", bus.out_valid, bus.ctrl_out, NOP_W);
    end
    step(1'b1, r_ins(5'd2, 5'd5, 5'd4, 6'd32), 1'b1);
    checks++;
    if ({seen_rdy, bus.out_valid, bus.ctrl_out} !== {1'b1, 1'b1, 5'd2, 5'd5, 5'd4, 8'h84}) begin
      errors++;
      $display("FAIL hazard_issue: got r%b v%b %h", seen_rdy, bus.out_valid, bus.ctrl_out);
    end
    step(1'b1, lw_ins(5'd1, 5'd3), 1'b1);
    step(1'b1, sw_ins(5'd6, 5'd3), 1'b1);
    checks++;
    if ({seen_rdy, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL hazard_sw_rt: got r%b v%b want r0 v0", seen_rdy, bus.out_valid);
    end
    step(1'b1, sw_ins(5'd6, 5'd3), 1'b1);
    checks++;
    if ({bus.out_valid, bus.ctrl_out} !== {1'b1, 5'd6, 5'd3, 5'd0, 8'h47}) begin
      errors++;
      $display("FAIL sw_word: got v%b %h", bus.out_valid, bus.ctrl_out);
    end
  endtask

  task automatic test_mul();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, r_ins(5'd1, 5'd2, 5'd6, 6'd50), 1'b1);
    checks++;
    if ({bus.out_valid, bus.mul_busy, bus.ctrl_out} !== {1'b1, 1'b1, 5'd1, 5'd2, 5'd6, 8'h88}) begin
      errors++;
      $display("FAIL mul_word: got v%b b%b %h", bus.out_valid, bus.mul_busy, bus.ctrl_out);
    end
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      step(1'b1, r_ins(5'd7, 5'd7, 5'd8, 6'd32), 1'b1);
      checks++;
      if ({seen_rdy, bus.out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL mul_stall_%0d: got r%b v%b want r0 v0", k, seen_rdy, bus.out_valid);
      end
    end
    step(1'b1, r_ins(5'd7, 5'd7, 5'd8, 6'd32), 1'b1);
    checks++;
    if ({seen_rdy, bus.out_valid, bus.mul_busy, bus.ctrl_out} !==
        {1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd8, 8'h84}) begin
      errors++;
      $display("FAIL mul_release: got r%b v%b b%b %h", seen_rdy, bus.out_valid, bus.mul_busy,
               bus.ctrl_out);
    end
  endtask

  task automatic test_out_stall();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, r_ins(5'd3, 5'd4, 5'd9, 6'd50), 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, r_ins(5'd1, 5'd1, 5'd1, 6'd37), 1'b0);
      checks++;
      if ({seen_rdy, bus.out_valid, bus.mul_busy, bus.ctrl_out} !==
          {1'b0, 1'b1, (k < 2), 5'd3, 5'd4, 5'd9, 8'h88}) begin
        errors++;
        $display("FAIL out_stall_%0d: got r%b v%b b%b %h want r0 v1 b%b", k, seen_rdy,
                 bus.out_valid, bus.mul_busy, bus.ctrl_out, (k < 2));
      end
    end
    step(1'b1, r_ins(5'd1, 5'd1, 5'd1, 6'd37), 1'b1);
    checks++;
    if ({seen_rdy, bus.out_valid, bus.ctrl_out} !== {1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 8'hB4}) begin
      errors++;
      $display("FAIL out_stall_release: got r%b v%b %h", seen_rdy, bus.out_valid, bus.ctrl_out);
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, {6'h3f, 26'h0123456}, 1'b1);
    checks++;
    if ({bus.out_valid, bus.illegal, bus.ctrl_out} !== {1'b1, 1'b1, NOP_W}) begin
      errors++;
      $display("FAIL bad_op: got v%b i%b %h", bus.out_valid, bus.illegal, bus.ctrl_out);
    end
    step(1'b1, r_ins(5'd1, 5'd2, 5'd3, 6'h2a), 1'b1);
    checks++;
    if ({bus.out_valid, bus.illegal, bus.ctrl_out} !== {1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 8'h94}) begin
      errors++;
      $display("FAIL bad_funct: got v%b i%b %h", bus.out_valid, bus.illegal, bus.ctrl_out);
    end
    step(1'b1, lw_ins(5'd4, 5'd0), 1'b1);
    step(1'b1, r_ins(5'd0, 5'd0, 5'd5, 6'd36), 1'b1);
    checks++;
    if ({seen_rdy, bus.out_valid, bus.illegal, bus.ctrl_out} !==
        {1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 8'hA4}) begin
      errors++;
      $display("FAIL lw_r0_no_hazard: got r%b v%b i%b %h", seen_rdy, bus.out_valid, bus.illegal,
               bus.ctrl_out);
    end
  endtask

  task automatic test_random();
    logic        m_valid, m_ill, m_lw, v, ordy, exp_rdy, hz;
    logic [22:0] m_word;
    logic [4:0]  m_rd;
    logic [31:0] ins;
    logic [5:0]  fn;
    logic [23:0] dec;
    int          m_cnt;
    step(1'b0, 32'h0, 1'b1);
    m_valid = 1'b0; m_ill = 1'b0; m_lw = 1'b0; m_word = NOP_W; m_rd = '0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0, 1: ins = lw_ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        2:    ins = sw_ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        3:    ins = $urandom;
        default: begin
          case ($urandom_range(0, 6))
            0: fn = 6'd32; 1: fn = 6'd34; 2: fn = 6'd36; 3: fn = 6'd37;
            4, 5: fn = 6'd50;
            default: fn = 6'($urandom);
          endcase
          ins = r_ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), fn);
        end
      endcase
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      hz = m_valid && m_lw && (m_rd != 5'd0) &&
           ((ins[25:21] == m_rd) ||
            (((ins[31:26] == 6'd7) || (ins[31:26] == 6'd9)) && (ins[20:16] == m_rd)));
      exp_rdy = (!m_valid || ordy) && (m_cnt == 0) && !hz;
      step(v, ins, ordy);
      checks++;
      if (seen_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready_%0d: got %b want %b", n, seen_rdy, exp_rdy);
      end
      if (m_cnt > 0) m_cnt--;
      if (!m_valid || ordy) begin
        if (v && exp_rdy) begin
          dec     = ref_decode(ins);
          m_ill   = dec[23];
          m_word  = dec[22:0];
          m_valid = 1'b1;
          m_lw    = (ins[31:26] == 6'd8);
          m_rd    = ins[20:16];
          if (ins[31:26] == 6'd7 && ins[5:0] == 6'd50) m_cnt = MUL_LAT - 1;
        end else begin
          m_valid = 1'b0; m_ill = 1'b0; m_lw = 1'b0; m_word = NOP_W;
        end
      end
      checks++;
      if ({bus.out_valid, bus.illegal, bus.mul_busy, bus.ctrl_out} !==
          {m_valid, m_ill, (m_cnt != 0), m_word}) begin
        errors++;
        $display("FAIL rnd_out_%0d: got v%b i%b b%b %h want v%b i%b b%b %h", n, bus.out_valid,
                 bus.illegal, bus.mul_busy, bus.ctrl_out, m_valid, m_ill, (m_cnt != 0), m_word);
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_add();
    test_load_use();
    test_mul();
    test_out_stall();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
